// File: rtl/march_bist_sequencer.sv
// March C- BIST sequencer for a single-port SRAM. It drives the SRAM ports
// directly, compares each read one cycle later against the expected
// background, and logs the first failing address/element plus a
// saturating mismatch count.
//
// state | meaning
// IDLE  | SRAM on the normal path, waiting for start
// RUN   | one March op per cycle on the SRAM ports
// DRAIN | no access; the compare for the final read completes
// DONE  | test finished, results held until the next start
module march_bist_sequencer #(
  parameter int SIZE   = 6,
  parameter int LENGTH = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LENGTH-1:0] ramout,
  output logic [SIZE-1:0]   ramaddr,
  output logic [LENGTH-1:0] ramin,
  output logic              rwbar,
  output logic              cs,
  output logic              NbarT,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [SIZE-1:0]   fail_addr,
  output logic [2:0]        fail_elem,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [SIZE-1:0]  ADDR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state;

  // op currently presented on the SRAM ports
  logic [2:0]      op_elem;
  logic [SIZE-1:0] op_addr;
  logic            op_phase;

  logic [2:0]      nx_elem;
  logic [SIZE-1:0] nx_addr;
  logic            nx_phase;
  logic            last_op;
  logic            at_end;

  logic            chk_valid;
  logic            chk_exp;
  logic [SIZE-1:0] chk_addr;
  logic [2:0]      chk_elem;
  logic            mismatch;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  // every element except the initial w0 opens with a read
  function automatic logic is_read(input logic [2:0] e, input logic p);
    return (e != 3'd0) && !p;
  endfunction

  // elements 2 and 4 read ones; elements 1 and 3 write ones
  function automatic logic read_bg(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic write_bg(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  assign at_end   = is_down(op_elem) ? (op_addr == '0) : (op_addr == ADDR_MAX);
  assign mismatch = (ramout != {LENGTH{chk_exp}});

  // successor of the op on the ports: next op at this address, else step
  // the address, else open the next element at its start address
  always_comb begin
    nx_elem  = op_elem;
    nx_addr  = op_addr;
    nx_phase = 1'b0;
    last_op  = 1'b0;
    if (two_ops(op_elem) && !op_phase) begin
      nx_phase = 1'b1;
    end else if (at_end) begin
      if (op_elem == 3'd5) begin
        last_op = 1'b1;
      end else begin
        nx_elem = op_elem + 3'd1;
        nx_addr = is_down(op_elem + 3'd1) ? ADDR_MAX : '0;
      end
    end else if (is_down(op_elem)) begin
      nx_addr = op_addr - 1'b1;
    end else begin
      nx_addr = op_addr + 1'b1;
    end
  end

  // FSM, registered SRAM ports, one-stage read compare and result log
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_elem    <= 3'd0;
      op_addr    <= '0;
      op_phase   <= 1'b0;
      ramaddr    <= '0;
      ramin      <= '0;
      rwbar      <= 1'b1;
      cs         <= 1'b0;
      NbarT      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_count <= '0;
      chk_valid  <= 1'b0;
      chk_exp    <= 1'b0;
      chk_addr   <= '0;
      chk_elem   <= 3'd0;
    end else begin
      chk_valid <= (state == RUN) && !abort && is_read(op_elem, op_phase);
      chk_exp   <= read_bg(op_elem);
      chk_addr  <= op_addr;
      chk_elem  <= op_elem;

      // an abort discards the compare still in flight
      if (chk_valid && !abort && mismatch) begin
        if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
        if (!fail) begin
          fail_addr <= chk_addr;
          fail_elem <= chk_elem;
        end
        fail <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            done       <= 1'b0;
            busy       <= 1'b1;
            NbarT      <= 1'b1;
            cs         <= 1'b1;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            fail_count <= '0;
            op_elem    <= 3'd0;
            op_addr    <= '0;
            op_phase   <= 1'b0;
            ramaddr    <= '0;
            rwbar      <= 1'b0;
            ramin      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            cs    <= 1'b0;
            NbarT <= 1'b0;
            busy  <= 1'b0;
            rwbar <= 1'b1;
            ramin <= '0;
          end else if (last_op) begin
            state <= DRAIN;
            cs    <= 1'b0;
            rwbar <= 1'b1;
            ramin <= '0;
          end else begin
            op_elem  <= nx_elem;
            op_addr  <= nx_addr;
            op_phase <= nx_phase;
            ramaddr  <= nx_addr;
            rwbar    <= is_read(nx_elem, nx_phase);
            ramin    <= is_read(nx_elem, nx_phase) ? '0 : {LENGTH{write_bg(nx_elem)}};
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          NbarT <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist_sequencer.sv
// Bench for march_bist_sequencer: SRAM model with one injectable stuck-at
// bit, a March C- op list built from the element table, and a monitor that
// checks ports and the result log on every cycle of a run.
module tb_march_bist_sequencer;

  localparam int SIZE   = 6;
  localparam int LENGTH = 8;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << SIZE;
  localparam int NOPS   = 10 * DEPTH;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [LENGTH-1:0] ramout;
  logic [SIZE-1:0]   ramaddr;
  logic [LENGTH-1:0] ramin;
  logic              rwbar, cs, NbarT, busy, done, fail;
  logic [SIZE-1:0]   fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_count;

  march_bist_sequencer #(.SIZE(SIZE), .LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ramout(ramout),
    .ramaddr(ramaddr), .ramin(ramin), .rwbar(rwbar), .cs(cs), .NbarT(NbarT),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // SRAM with one optional stuck-at bit seen on reads
  logic [LENGTH-1:0] mem [DEPTH];
  bit                flt_en;
  logic [SIZE-1:0]   flt_addr;
  int                flt_bit;
  logic              flt_val;

  function automatic logic [LENGTH-1:0] read_word(input logic [SIZE-1:0] a);
    logic [LENGTH-1:0] w;
    w = mem[a];
    if (flt_en && a == flt_addr) w[flt_bit] = flt_val;
    return w;
  endfunction

  always @(posedge clk) begin
    if (cs && !rwbar) mem[ramaddr] <= ramin;
    if (cs && rwbar) ramout <= read_word(ramaddr);
  end

  // March C- op list: per element, direction and op codes (0 w0, 1 w1, 2 r0, 3 r1)
  int   e_nops [6]    = '{1, 2, 2, 2, 2, 1};
  bit   e_down [6]    = '{0, 0, 0, 1, 1, 0};
  int   e_code [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 2}};
  logic            tb_rd   [NOPS];
  logic            tb_bg   [NOPS];
  logic [SIZE-1:0] tb_addr [NOPS];
  logic [2:0]      tb_elem [NOPS];
  int              n_ops;

  task automatic build_model();
    n_ops = 0;
    for (int e = 0; e < 6; e++)
      for (int s = 0; s < DEPTH; s++)
        for (int o = 0; o < e_nops[e]; o++) begin
          if (n_ops < NOPS) begin
            tb_rd[n_ops]   = (e_code[e][o] >= 2);
            tb_bg[n_ops]   = (e_code[e][o] % 2 == 1);
            tb_addr[n_ops] = e_down[e] ? SIZE'(DEPTH - 1 - s) : SIZE'(s);
            tb_elem[n_ops] = 3'(e);
          end
          n_ops++;
        end
  endtask

  function automatic bit op_mismatch(input int i);
    return tb_rd[i] && flt_en && (tb_addr[i] == flt_addr) && (flt_val != tb_bg[i]);
  endfunction

  task automatic pin(input int i, input logic rd, input logic bg, input int el, input int a);
    chk($sformatf("model.op%0d.rd", i), 32'(tb_rd[i]), 32'(rd));
    chk($sformatf("model.op%0d.bg", i), 32'(tb_bg[i]), 32'(bg));
    chk($sformatf("model.op%0d.elem", i), 32'(tb_elem[i]), 32'(el));
    chk($sformatf("model.op%0d.addr", i), 32'(tb_addr[i]), 32'(a));
  endtask

  // expected result log, advanced by the monitor
  bit              m_fail;
  int              m_cnt;
  logic [SIZE-1:0] m_addr;
  logic [2:0]      m_elem;

  bit   mon_en = 1'b0;
  int   mon_idx, stop_at;
  bit   stop_rst;
  logic [LENGTH-1:0] exp_in;

  task automatic check_reset(input string tag);
    chk({tag, ".NbarT"}, 32'(NbarT), 32'd0);
    chk({tag, ".cs"}, 32'(cs), 32'd0);
    chk({tag, ".rwbar"}, 32'(rwbar), 32'd1);
    chk({tag, ".ramaddr"}, 32'(ramaddr), 32'd0);
    chk({tag, ".ramin"}, 32'(ramin), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".fail"}, 32'(fail), 32'd0);
    chk({tag, ".fail_addr"}, 32'(fail_addr), 32'd0);
    chk({tag, ".fail_elem"}, 32'(fail_elem), 32'd0);
    chk({tag, ".fail_count"}, 32'(fail_count), 32'd0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, ".fail"}, 32'(fail), 32'(m_fail));
    chk({tag, ".fail_count"}, 32'(fail_count), 32'(m_cnt));
    chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(m_addr));
    chk({tag, ".fail_elem"}, 32'(fail_elem), 32'(m_elem));
  endtask

  // per-cycle compare; index k is the k-th cycle after start was taken
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (mon_idx == stop_at) begin
        if (stop_rst) check_reset("rst_mid");
        else begin
          chk("abort.cs", 32'(cs), 32'd0);
          chk("abort.NbarT", 32'(NbarT), 32'd0);
          chk("abort.busy", 32'(busy), 32'd0);
          chk("abort.done", 32'(done), 32'd0);
          check_log("abort");
        end
        mon_en = 1'b0;
      end else begin
        if (mon_idx >= 2 && mon_idx - 2 < n_ops && op_mismatch(mon_idx - 2)) begin
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (!m_fail) begin
            m_addr = tb_addr[mon_idx - 2];
            m_elem = tb_elem[mon_idx - 2];
          end
          m_fail = 1'b1;
        end
        if (mon_idx < n_ops) begin
          exp_in = tb_rd[mon_idx] ? '0 : {LENGTH{tb_bg[mon_idx]}};
          chk("run.busy", 32'(busy), 32'd1);
          chk("run.cs", 32'(cs), 32'd1);
          chk("run.NbarT", 32'(NbarT), 32'd1);
          chk("run.done", 32'(done), 32'd0);
          chk($sformatf("run.rwbar[%0d]", mon_idx), 32'(rwbar), 32'(tb_rd[mon_idx]));
          chk($sformatf("run.ramaddr[%0d]", mon_idx), 32'(ramaddr), 32'(tb_addr[mon_idx]));
          chk($sformatf("run.ramin[%0d]", mon_idx), 32'(ramin), 32'(exp_in));
        end else if (mon_idx == n_ops) begin
          chk("drain.cs", 32'(cs), 32'd0);
          chk("drain.NbarT", 32'(NbarT), 32'd1);
          chk("drain.busy", 32'(busy), 32'd1);
          chk("drain.done", 32'(done), 32'd0);
        end else begin
          chk("done.done", 32'(done), 32'd1);
          chk("done.busy", 32'(busy), 32'd0);
          chk("done.NbarT", 32'(NbarT), 32'd0);
          chk("done.cs", 32'(cs), 32'd0);
          mon_en = 1'b0;
        end
        check_log($sformatf("log[%0d]", mon_idx));
        mon_idx++;
      end
    end
  end

  // called at a negedge; returns at the negedge of RUN cycle 0
  task automatic start_run(input int stop, input bit stop_is_rst);
    start    = 1'b1;
    m_fail   = 1'b0;
    m_cnt    = 0;
    m_addr   = '0;
    m_elem   = '0;
    mon_idx  = 0;
    stop_at  = stop;
    stop_rst = stop_is_rst;
    mon_en   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_mon(input string nm, input int lim);
    int i = 0;
    while (mon_en && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk({nm, ".timeout"}, 32'(mon_en), 32'd0);
    mon_en = 1'b0;
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input logic v);
    flt_en   = en;
    flt_addr = SIZE'(a);
    flt_bit  = b;
    flt_val  = v;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; ramout = '0;
    set_fault(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    build_model();

    // model pins: op count, first op, element 1 start, element 3 start, last op
    chk("model.nops", 32'(n_ops), 32'd640);
    pin(0, 1'b0, 1'b0, 0, 0);
    pin(64, 1'b1, 1'b0, 1, 0);
    pin(65, 1'b0, 1'b1, 1, 0);
    pin(320, 1'b1, 1'b0, 3, 63);
    pin(321, 1'b0, 1'b1, 3, 63);
    pin(639, 1'b1, 1'b0, 5, 63);

    // 1: reset held with start high
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // 2: fault-free run
    start_run(-1, 1'b0);
    wait_mon("t2", 700);
    chk("t2.done", 32'(done), 32'd1);
    chk("t2.fail", 32'(fail), 32'd0);
    chk("t2.fail_count", 32'(fail_count), 32'd0);

    // 3: bit 3 of address 5 stuck at 0
    set_fault(1'b1, 5, 3, 1'b0);
    start_run(-1, 1'b0);
    wait_mon("t3", 700);
    chk("t3.fail", 32'(fail), 32'd1);
    chk("t3.fail_addr", 32'(fail_addr), 32'd5);
    chk("t3.fail_elem", 32'(fail_elem), 32'd2);
    chk("t3.fail_count", 32'(fail_count), 32'd2);

    // 4: bit 0 of address 63 stuck at 1
    set_fault(1'b1, 63, 0, 1'b1);
    start_run(-1, 1'b0);
    wait_mon("t4", 700);
    chk("t4.fail", 32'(fail), 32'd1);
    chk("t4.fail_addr", 32'(fail_addr), 32'd63);
    chk("t4.fail_elem", 32'(fail_elem), 32'd1);
    chk("t4.fail_count", 32'(fail_count), 32'd3);

    // 5: abort at RUN cycle 100 after one logged failure, then restart
    set_fault(1'b1, 5, 0, 1'b1);
    start_run(101, 1'b0);
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5.fail", 32'(fail), 32'd1);
    chk("t5.fail_addr", 32'(fail_addr), 32'd5);
    chk("t5.fail_elem", 32'(fail_elem), 32'd1);
    chk("t5.fail_count", 32'(fail_count), 32'd1);
    @(negedge clk);
    chk("t5.idle_busy", 32'(busy), 32'd0);
    chk("t5.idle_cs", 32'(cs), 32'd0);
    set_fault(1'b0, 0, 0, 1'b0);
    abort = 1'b1;
    start_run(-1, 1'b0);
    wait_mon("t5b", 700);
    chk("t5b.done", 32'(done), 32'd1);
    chk("t5b.fail_count", 32'(fail_count), 32'd0);

    // 6: start re-pulsed mid-run is ignored; reset mid-run clears everything
    start_run(301, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (289) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6.monitor_stopped", 32'(mon_en), 32'd0);
    check_reset("t6.after_rst");
    @(negedge clk);
    chk("t6.idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/march_bist_sequencer.md
Name: march_bist_sequencer

Overview:
- Replaces the simple up-counter BIST controller with a March C- sequencer for the single-port SRAM.
- Drives SRAM address, data, rwbar and cs directly. Owns the NbarT select for the normal/BIST muxes.
- Checks every read against the expected background and logs the first failing address and element, plus a saturating fail count.
- Sits between the top-level start/abort inputs and the SRAM-side muxes in the BIST wrapper.

Parameters:
SIZE, 6, SRAM address width; depth = 2**SIZE
LENGTH, 8, SRAM data width
CNT_W, 8, fail counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin test when IDLE or DONE (level sampled, edge not required)
abort  input  1  synchronous abort of a running test
ramout  input  LENGTH  SRAM read data
ramaddr  output  SIZE  SRAM address (registered)
ramin  output  LENGTH  SRAM write data (registered)
rwbar  output  1  1 = read, 0 = write (registered)
cs  output  1  SRAM chip select (registered)
NbarT  output  1  1 = BIST owns SRAM (mux select)
busy  output  1  test in progress (RUN or DRAIN)
done  output  1  test completed normally; held until next start
fail  output  1  sticky: at least one read mismatch
fail_addr  output  SIZE  address of first mismatch
fail_elem  output  3  March element index (0-5) of first mismatch
fail_count  output  CNT_W  mismatch count, saturates at 2**CNT_W-1

Behaviour:
- Reset values: NbarT=0, cs=0, rwbar=1, ramaddr=0, ramin=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_count=0. State = IDLE.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1: next edge enters RUN, clears done, fail, fail_addr, fail_elem, fail_count, and presents the first op.
- start is ignored in RUN and DRAIN.
- March C- elements, executed in index order:
  - 0: up (w0)
  - 1: up (r0,w1)
  - 2: up (r1,w0)
  - 3: down (r0,w1)
  - 4: down (r1,w0)
  - 5: up (r0)
- Backgrounds: 0 = all LENGTH bits 0; 1 = all bits 1.
- Up order: address 0 to 2**SIZE-1. Down order: 2**SIZE-1 to 0.
- Op order within an element: all ops of the element at one address, then step the address.
- One op per cycle, no bubbles. Total RUN cycles = 10*2**SIZE (640 at SIZE=6).
- Element boundaries: the last op of element k is followed directly by the first op of element k+1 at its start address. No idle cycle between elements.
- Port driving in RUN:
  - cs=1 and NbarT=1 on every cycle.
  - Write: rwbar=0, ramin=background.
  - Read: rwbar=1, ramin=0.
- Read timing:
  - Op on ports in cycle N; ramout is valid in cycle N+1.
  - Expected data, address and element are pipelined one stage and compared in cycle N+1.
  - fail, fail_count and the first-fail registers update at the edge ending N+1.
- First-fail capture: fail_addr and fail_elem load only on a mismatch while fail=0.
- Simultaneous mismatch and saturation: fail_count holds at its maximum; fail is still set.
- After the last op: RUN goes to DRAIN for 1 cycle (cs=0, NbarT=1) so the final compare completes, then DONE.
- DONE: done=1, busy=0, NbarT=0, cs=0. Result registers hold.
- abort in RUN or DRAIN:
  - Next edge goes to IDLE with cs=0, NbarT=0, busy=0, done=0.
  - Log registers keep their values.
  - A compare pending in the pipeline is discarded.
- rst at any time: every output returns to its reset value at the next edge, including mid-test.
- abort and start asserted together in IDLE: start wins. abort has no effect outside RUN and DRAIN.

Test Plan:
1. Assert rst for 2 cycles with start=1 -> every output at its reset value, state IDLE, no SRAM access.
2. Fault-free SRAM model, SIZE=6, 1-cycle start pulse:
   - busy=1 from the next cycle; first op is w0 @0, cs=1.
   - Op 64 is r0 @0, op 65 is w1 @0.
   - Element 3 starts at address 63.
   - done=1 after 640 RUN cycles + 1 DRAIN cycle; fail=0, fail_count=0.
3. Bit 3 of address 5 stuck-at-0 -> fail=1, fail_addr=5, fail_elem=2, fail_count=2 (r1 reads in elements 2 and 4).
4. Bit 0 of address 63 stuck-at-1 -> fail_addr=63, fail_elem=1, fail_count=3 (r0 reads in elements 1, 3, 5).
5. abort at RUN cycle 100 -> next cycle IDLE, NbarT=0, cs=0, done=0. A following start restarts at w0 @0 with counts cleared.
6. start re-pulsed at RUN cycle 10 -> ignored, op sequence unchanged. Then rst at RUN cycle 300 -> all outputs reset on the next cycle.
